// File: rtl/core_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// controller states and small decode helpers used by the top and divider.
package core_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Ops 4..7 use the iterative divider.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM/REMU return the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  // DIV/REM are signed, DIVU/REMU are unsigned.
  function automatic logic op_div_signed(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // RS1 is treated as signed for MULH and MULHSU.
  function automatic logic op_mul_rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // RS2 is treated as signed only for MULH.
  function automatic logic op_mul_rs2_signed(input logic [2:0] op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/core_mdu_div.sv
// Iterative radix-2 restoring divider on operand magnitudes. One quotient
// bit per cycle after start; done is high for the cycle after the last step.
// Signs are reapplied on the outputs (quotient toward zero, remainder
// follows the dividend). Divide-by-zero and signed overflow are handled by
// the caller and never started here.
module core_mdu_div
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);

  // Two's complement negate when en is set.
  function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
    return en ? ((~v) + XLEN'(1)) : v;
  endfunction

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic            a_neg, b_neg, step, ge;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;

  assign done = run_q & (cnt_q == CNT_W'(XLEN));
  assign step = run_q & ~done;

  assign a_neg = is_signed & dividend[XLEN-1];
  assign b_neg = is_signed & divisor[XLEN-1];

  // Partial remainder shifted left with the next dividend bit; the
  // subtraction result always fits XLEN bits when it is kept.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign sub     = shifted[XLEN-1:0] - dvs_q;

  // Next-state for run control and the remainder/quotient shift registers.
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      quo_d  = neg_if(a_neg, dividend);
      rem_d  = '0;
      dvs_d  = neg_if(b_neg, divisor);
      negq_d = a_neg ^ b_neg;
      negr_d = a_neg;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      quo_d = {quo_q[XLEN-2:0], ge};
      rem_d = ge ? sub : shifted[XLEN-1:0];
    end else if (done) begin
      run_d = 1'b0;
    end
  end

  // Control flops: cleared by reset so no stale done survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  // Datapath flops: only meaningful while run_q is set.
  always_ff @(posedge clk) begin
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign quotient  = neg_if(negq_q, quo_q);
  assign remainder = neg_if(negr_q, rem_q);

endmodule

// File: rtl/core_mdu.sv
// Multiply/divide unit. A request is accepted in IDLE; multiplies run
// through a MUL_LAT-deep product pipeline, divides through core_mdu_div.
// The result is held in DONE until the consumer takes it. FLUSH aborts
// whatever is in flight. MUL_LAT must lie in 1..4.
module core_mdu
  import core_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            I_VALID,
  output logic            I_READY,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  output logic            O_VALID,
  input  logic            O_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam int CNT_W = $clog2(XLEN + 2);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             o_valid_q, o_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             spec_q, spec_d;
  mdu_op_e          op_q, op_d;
  logic [XLEN-1:0]  spec_res_q, spec_res_d;

  logic              accept;
  logic              div_zero, div_ovf, div_special;
  logic [XLEN-1:0]   special_res;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_w, b_w, prod_in;
  logic [2*XLEN-1:0] prod_p [MUL_LAT];
  logic [XLEN-1:0]   mul_res, div_res;
  logic              div_start, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign I_READY = (state_q == ST_IDLE) & ~FLUSH;
  assign accept  = I_VALID & I_READY;
  assign O_VALID = o_valid_q;
  assign RESULT  = result_q;
  assign BUSY    = (state_q != ST_IDLE);

  // Divide corner cases resolved at accept time without iterating.
  assign div_zero    = (RS2 == '0);
  assign div_ovf     = op_div_signed(OP) && (RS1 == MOST_NEG) && (RS2 == ALL_ONES);
  assign div_special = div_zero | div_ovf;
  assign special_res = div_zero ? (op_is_rem(OP) ? RS1 : ALL_ONES)
                                : (op_is_rem(OP) ? '0  : RS1);

  // Operands extended to 2*XLEN; the truncated product is exact for all
  // signed/unsigned combinations because the true product fits the width.
  assign a_sx    = op_mul_rs1_signed(OP) & RS1[XLEN-1];
  assign b_sx    = op_mul_rs2_signed(OP) & RS2[XLEN-1];
  assign a_w     = {{XLEN{a_sx}}, RS1};
  assign b_w     = {{XLEN{b_sx}}, RS2};
  assign prod_in = a_w * b_w;

  assign mul_res = (op_q == OP_MUL) ? prod_p[MUL_LAT-1][XLEN-1:0]
                                    : prod_p[MUL_LAT-1][2*XLEN-1:XLEN];
  assign div_res = op_is_rem(op_q) ? div_rem : div_quo;

  assign div_start = accept & op_is_div(OP) & ~div_special;

  core_mdu_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (div_start),
    .abort    (FLUSH),
    .dividend (RS1),
    .divisor  (RS2),
    .is_signed(op_div_signed(OP)),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Controller next-state: accept, multiply countdown, divide wait,
  // result hold; FLUSH overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_valid_d  = o_valid_q;
    result_d   = result_q;
    spec_d     = spec_q;
    op_d       = op_q;
    spec_res_d = spec_res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = mdu_op_e'(OP);
          cnt_d      = '0;
          spec_d     = op_is_div(OP) & div_special;
          spec_res_d = special_res;
          state_d    = op_is_div(OP) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          state_d   = ST_DONE;
          o_valid_d = 1'b1;
          result_d  = mul_res;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (spec_q) begin
          state_d   = ST_DONE;
          o_valid_d = 1'b1;
          result_d  = spec_res_q;
        end else if (div_done) begin
          state_d   = ST_DONE;
          o_valid_d = 1'b1;
          result_d  = div_res;
        end
      end
      ST_DONE: begin
        if (O_READY) begin
          state_d   = ST_IDLE;
          o_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) begin
      state_d   = ST_IDLE;
      o_valid_d = 1'b0;
      cnt_d     = '0;
      spec_d    = 1'b0;
    end
  end

  // Controller and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      result_q  <= '0;
      spec_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      result_q  <= result_d;
      spec_q    <= spec_d;
    end
  end

  // Latched op and precomputed corner-case result; no reset needed.
  always_ff @(posedge CLK) begin
    op_q       <= op_d;
    spec_res_q <= spec_res_d;
  end

  // Product pipeline: stage 0 captures at accept, later stages shift.
  always_ff @(posedge CLK) begin
    if (accept) prod_p[0] <= prod_in;
    for (int k = 1; k < MUL_LAT; k++) prod_p[k] <= prod_p[k-1];
  end

endmodule

// File: doc/core_mdu.md
CORE_MDU -- requirements
Module: core_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter MUL_LAT, default 2, multiply latency in cycles (legal range 1..4).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FLUSH  input  1  abort any in-flight operation.
REQ-006 SHALL have port I_VALID  input  1  request valid.
REQ-007 SHALL have port I_READY  output  1  block can accept a request.
REQ-008 SHALL have port OP  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port RS1  input  XLEN  operand A.
REQ-010 SHALL have port RS2  input  XLEN  operand B.
REQ-011 SHALL have port O_VALID  output  1  RESULT valid.
REQ-012 SHALL have port O_READY  input  1  consumer takes RESULT.
REQ-013 SHALL have port RESULT  output  XLEN  registered result.
REQ-014 SHALL have port BUSY  output  1  state not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; I_READY = (state==IDLE) & !FLUSH.
REQ-016 SHALL accept on the rising edge with I_VALID & I_READY, latching OP, RS1, RS2.
REQ-017 SHALL, for OP 0..3, enter MUL and assert O_VALID exactly MUL_LAT cycles after the accept edge.
REQ-018 SHALL produce MUL low XLEN bits; MULH signed*signed high; MULHSU signed RS1 * unsigned RS2 high; MULHU unsigned high; full product 2*XLEN bits.
REQ-019 SHALL, for OP 4..7, enter DIV and run one radix-2 restoring step per cycle, asserting O_VALID XLEN+1 cycles after the accept edge.
REQ-020 SHALL, on RS2==0, skip iteration and go to DONE next cycle: DIV/DIVU give all-ones, REM/REMU give RS1.
REQ-021 SHALL, on signed overflow (RS1 = most negative, RS2 = -1, DIV/REM), go to DONE next cycle: DIV gives RS1, REM gives 0.
REQ-022 SHALL give signed quotient truncated toward zero and remainder with the sign of RS1.
REQ-023 SHALL hold RESULT and O_VALID stable in DONE until O_READY; on O_VALID & O_READY return to IDLE, deasserting O_VALID next cycle.
REQ-024 SHALL not accept a new request in the cycle that DONE is left (one bubble between operations).
REQ-025 SHALL, on FLUSH in any state, go to IDLE next edge, drop O_VALID, and discard the operation; FLUSH with I_VALID in IDLE accepts nothing.
REQ-026 SHALL ignore OP/RS1/RS2 changes after acceptance.
REQ-027 SHALL use a cycle counter of width clog2(XLEN+2) that saturates-free cannot wrap within one operation.

Reset
REQ-028 SHALL, while RST_N low, force state IDLE, O_VALID 0, RESULT 0, BUSY 0, counter 0, irrespective of CLK.
REQ-029 SHALL, on reset mid-operation, discard the operation with no O_VALID after release.
REQ-030 SHALL present I_READY 1 on the first edge after RST_N release.

Structure
REQ-031 SHALL place OP encoding and FSM state enum in shared package core_mdu_pkg.
REQ-032 SHALL instantiate the iterative divider as sub-module core_mdu_div (start, operands, signed flag, done, quotient, remainder).
REQ-033 SHALL implement the multiplier as a MUL_LAT-deep register pipeline inside core_mdu.

Verification
REQ-034 SHALL check MULH RS1=0x80000000, RS2=0x80000000 -> RESULT 0x40000000, O_VALID exactly 2 cycles after accept.
REQ-035 SHALL check DIV RS1=-7, RS2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; O_VALID 33 cycles after accept.
REQ-036 SHALL check DIVU RS1=5, RS2=0 -> 0xFFFFFFFF and REMU -> 5, both 1 cycle after accept.
REQ-037 SHALL check DIV RS1=0x80000000, RS2=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-038 SHALL check O_READY held low 10 cycles in DONE -> RESULT stable, I_READY 0; FLUSH at divide cycle 10 -> IDLE, no O_VALID.
REQ-039 SHALL check RST_N asserted mid-divide -> outputs 0 immediately, I_READY 1 after release.
